pipe_dmem_arb: RTL
==================

# pipe_dmem_arb

Data-memory port arbiter and sequencer between the EX/MEM pipeline register (MEM-stage load/store) and a DMA requester. It shares one single-port, variable-latency data memory between the two, and freezes the pipeline with `cpu_stall` until the MEM-stage access completes. It sits beside the EX/MEM register. Its `cpu_stall` feeds the write enables of all pipeline registers up to and including MEM/WB.

## Interface
- `STARVE_MAX`, default 4: number of consecutive CPU grants allowed while `dreq` is pending, range 1..15.
- `clk` in 1: rising-edge clock.
- `clrn` in 1: asynchronous, active-low reset.
- `mwreg` in 1: MEM-stage register write. Unused except as a lint sink.
- `mwmem` in 1: MEM-stage store request.
- `mm2reg` in 1: MEM-stage load request.
- `malu` in 32: MEM-stage address.
- `mb` in 32: MEM-stage store data.
- `cpu_stall` out 1: freezes the pipeline registers (combinational).
- `cpu_rdata` out 32: load result, registered.
- `dreq` in 1: DMA request (level).
- `dwe` in 1: DMA write.
- `daddr` in 32: DMA address.
- `dwdata` in 32: DMA write data.
- `dack` out 1: one-cycle DMA completion pulse.
- `drdata` out 32: DMA read result, registered.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: memory write enable, registered.
- `mem_addr` out 32: memory address, registered.
- `mem_wdata` out 32: memory write data, registered.
- `mem_rdata` in 32: memory read data.
- `mem_rdy` in 1: memory completion, sampled at `clk`.

## Operation
- Signal definitions:
  - `cpu_req = mwmem | mm2reg`.
  - A request with `mwmem=1` is a write. `mwmem` wins if both `mwmem` and `mm2reg` are set.
- State machine states: IDLE, C_BUSY, C_DONE, D_BUSY, D_DONE.
- IDLE:
  - `mem_req=0`.
  - If `cpu_req` is set and the DMA is not owed a turn, go to C_BUSY and latch `mem_we`, `mem_addr` and `mem_wdata` from `mwmem`, `malu` and `mb`.
  - Otherwise, if `dreq` is set, go to D_BUSY and latch from `dwe`, `daddr` and `dwdata`.
- C_BUSY / D_BUSY:
  - `mem_req=1`, with the latched fields held stable.
  - On an edge with `mem_rdy=1`, go to C_DONE or D_DONE.
  - On a read, capture `mem_rdata` into `cpu_rdata` or `drdata` respectively.
- C_DONE:
  - `mem_req=0` and `cpu_stall=0`, so the pipeline advances at the end of this cycle.
  - Next state is IDLE.
- D_DONE:
  - `mem_req=0` and `dack=1`.
  - `dreq` is ignored in this cycle.
  - Next state is IDLE.
- `cpu_stall = cpu_req & (state != C_DONE)`. The stall therefore covers IDLE arbitration, D_BUSY and D_DONE.
- Write-only accesses leave `cpu_rdata` and `drdata` unchanged.
- DMA rules:
  - Holds `dreq`, `dwe`, `daddr` and `dwdata` stable until `dack`.
  - May re-assert `dreq` in the cycle after `dack`.
- Fairness: see Configuration.
- Reset (`clrn=0`, asynchronous):
  - State IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `drdata` and `dack` are all 0.
  - Starvation counter is 0.
- Reset mid-transaction aborts the access immediately. No completion is reported afterwards for the aborted request.

## Timing
- CPU access with zero-wait memory (`mem_rdy=1`) takes 3 cycles: IDLE, C_BUSY, C_DONE.
  - `cpu_stall` is high for 2 cycles, then low for 1.
- Each cycle of `mem_rdy=0` in a BUSY state adds one cycle.
- DMA access with zero-wait memory takes 3 cycles, with `dack` in the third.
- `cpu_stall` and `dack` are glitch-free functions of state and registered inputs. No combinational path exists from `mem_rdy` to `cpu_stall`.
- `mem_rdy` sampled while not in a BUSY state is ignored.

## Configuration
- Macro `PIPE_DMEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A 4-bit counter increments on each IDLE→C_BUSY grant taken while `dreq=1`.
  - It clears on an IDLE→D_BUSY grant, or when `dreq=0` in IDLE.
  - When the counter equals `STARVE_MAX` and `dreq=1`, IDLE grants the DMA even if `cpu_req=1`.
- Not defined:
  - Strict CPU priority. The counter is absent, and the DMA is served only when `cpu_req=0` in IDLE.

## Test plan
- Load, `malu=0x100`, `mem_rdy=1`, `mem_rdata=0xDEADBEEF`:
  - `mem_req` high with `mem_addr=0x100` and `mem_we=0` for 1 cycle.
  - `cpu_rdata=0xDEADBEEF` in C_DONE.
  - `cpu_stall` reads 1,1,0.
- Store, `malu=0x40`, `mb=0x1234`, `mem_rdy` low for 3 cycles:
  - `mem_we=1` and `mem_wdata=0x1234` held for 4 cycles.
  - `cpu_stall` high for 5 cycles.
  - `cpu_rdata` unchanged.
- `cpu_req` and `dreq` (`daddr=0x200`, read) both set in IDLE:
  - CPU is served first.
  - DMA is granted in the next IDLE.
  - `dack` pulses exactly once with `drdata=mem_rdata`.
  - `cpu_stall` is 0 during D_BUSY only if `cpu_req` has dropped.
- Continuous `cpu_req` and `dreq`, `STARVE_MAX=4`:
  - With the macro defined, the DMA is granted after the 4th CPU grant and the counter returns to 0.
  - Without the macro, `dack` never occurs.
- `clrn` pulsed low during C_BUSY with `mem_rdy=0`:
  - `mem_req` falls immediately.
  - After release, the state is IDLE, all outputs are 0, and no C_DONE occurs for the aborted access.

Source files
------------

// File: rtl/pipe_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pipe_dmem_arb
// Purpose  : Shares one variable-latency data memory between the MEM-stage
//            load/store and a DMA requester. While the MEM-stage access is
//            not yet complete, cpu_stall holds the pipeline.
// Options  : PIPE_DMEM_ARB_STARVE_GUARD_EN adds a DMA anti-starvation counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_dmem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic        dack,
    output logic [31:0] drdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        C_BUSY = 3'd1,
        C_DONE = 3'd2,
        D_BUSY = 3'd3,
        D_DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] drdata_q;
    logic        dack_q;

    logic cpu_req;
    logic dma_owed;

    assign cpu_req = mwmem | mm2reg;

`ifdef PIPE_DMEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q;

    assign dma_owed = dreq && (starve_cnt_q == 4'(STARVE_MAX));

    // Counts CPU grants taken while the DMA waits; any DMA grant or an idle
    // DMA clears it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            starve_cnt_q <= 4'd0;
        end else if (state_q == IDLE) begin
            if (!dreq || dma_owed || !cpu_req) begin
                starve_cnt_q <= 4'd0;
            end else begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

    logic unused_sink;
    assign unused_sink = mwreg;
`else
    assign dma_owed = 1'b0;

    logic unused_sink;
    assign unused_sink = mwreg ^ (STARVE_MAX == 0);
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            cpu_rdata_q <= 32'd0;
            drdata_q    <= 32'd0;
            dack_q      <= 1'b0;
        end else begin
            dack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req && !dma_owed) begin
                        state_q     <= C_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mwmem;
                        mem_addr_q  <= malu;
                        mem_wdata_q <= mb;
                    end else if (dreq) begin
                        state_q     <= D_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dwe;
                        mem_addr_q  <= daddr;
                        mem_wdata_q <= dwdata;
                    end
                end
                C_BUSY: begin
                    if (mem_rdy) begin
                        state_q   <= C_DONE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) cpu_rdata_q <= mem_rdata;
                    end
                end
                D_BUSY: begin
                    if (mem_rdy) begin
                        state_q   <= D_DONE;
                        mem_req_q <= 1'b0;
                        dack_q    <= 1'b1;
                        if (!mem_we_q) drdata_q <= mem_rdata;
                    end
                end
                C_DONE:  state_q <= IDLE;
                D_DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall depends only on state and the pipeline-register inputs, never on mem_rdy.
    assign cpu_stall = cpu_req & (state_q != C_DONE);
    assign cpu_rdata = cpu_rdata_q;
    assign drdata    = drdata_q;
    assign dack      = dack_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
